// File: rtl/lockstep_shadow_checker.sv
// Lockstep checker for the single-cycle MIPS-subset CPU: shadow register file,
// per-retirement write-port compare, streaming error FIFO and stall classification.
//
// state | meaning
// RUN   | checking retirements, counting, watching for a parked PC
// DONE  | PC parked at END_PC; checking stopped, FIFO still drains
// HANG  | PC parked elsewhere; checking stopped, FIFO still drains
module lockstep_shadow_checker #(
   parameter int unsigned NUM_REGS    = 32,
   parameter int unsigned ERR_DEPTH   = 8,
   parameter int unsigned TIMEOUT_CYC = 16,
   parameter logic [31:0] END_PC      = 32'h3FC,
   parameter bit          RESYNC      = 1'b1
) (
   input  logic        IF_CLK,
   input  logic        IF_RESET_N,
   input  logic [31:0] IF_PC,
   input  logic [31:0] IF_INSTRUCTION,
   input  logic        IF_RETIRE,
   input  logic        IF_WE,
   input  logic [4:0]  IF_WADDR,
   input  logic [31:0] IF_WDATA,
   output logic        ERR_VALID,
   input  logic        ERR_READY,
   output logic [1:0]  ERR_CODE,
   output logic [31:0] ERR_PC,
   output logic [4:0]  ERR_REG,
   output logic [31:0] ERR_EXP,
   output logic [31:0] ERR_GOT,
   output logic        ERR_OVERFLOW,
   output logic [31:0] RETIRED_CNT,
   output logic [15:0] ERR_CNT,
   output logic        DONE,
   output logic        HANG
);

   localparam int unsigned PW = $clog2(ERR_DEPTH);
   localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0] TMR_RELOAD = TW'(TIMEOUT_CYC);

   localparam logic [1:0] ST_RUN  = 2'd0;
   localparam logic [1:0] ST_DONE = 2'd1;
   localparam logic [1:0] ST_HANG = 2'd2;

   logic [1:0]    state;
   logic [31:0]   prev_pc;
   logic [TW-1:0] stall_tmr;

   // Entries at or above NUM_REGS are never written, so they read back as 0.
   logic [31:0] shadow [32];

   logic [5:0]  op, funct;
   logic [4:0]  rs_idx, rt_idx, rd_idx, shamt;
   logic [31:0] rs_val, rt_val, exp_val;
   logic [4:0]  dest;
   logic        writer, illegal;

   logic        check_en, err_det, push_ok, pop, full;
   logic [1:0]  err_code;
   logic [4:0]  err_reg;
   logic [31:0] err_exp, err_got;
   logic        sh_we;
   logic [4:0]  sh_idx;
   logic [31:0] sh_val;

   logic [1:0]  q_code [ERR_DEPTH];
   logic [31:0] q_pc   [ERR_DEPTH];
   logic [4:0]  q_reg  [ERR_DEPTH];
   logic [31:0] q_exp  [ERR_DEPTH];
   logic [31:0] q_got  [ERR_DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [PW:0]   count;

   function automatic logic [31:0] qb_add(input logic [31:0] a, input logic [31:0] b,
                                          input logic sat);
      logic [8:0] s;
      qb_add = '0;
      for (int i = 0; i < 4; i++) begin
         s = {1'b0, a[8*i +: 8]} + {1'b0, b[8*i +: 8]};
         qb_add[8*i +: 8] = (sat && s[8]) ? 8'hFF : s[7:0];
      end
   endfunction

   assign op     = IF_INSTRUCTION[31:26];
   assign rs_idx = IF_INSTRUCTION[25:21];
   assign rt_idx = IF_INSTRUCTION[20:16];
   assign rd_idx = IF_INSTRUCTION[15:11];
   assign shamt  = IF_INSTRUCTION[10:6];
   assign funct  = IF_INSTRUCTION[5:0];
   assign rs_val = shadow[rs_idx];
   assign rt_val = shadow[rt_idx];

   always_comb begin
      writer  = 1'b0;
      illegal = 1'b0;
      dest    = rd_idx;
      exp_val = '0;
      case (op)
         6'b000000: begin
            writer = 1'b1;
            case (funct)
               6'b100000: exp_val = rs_val + rt_val;
               6'b100010: exp_val = rs_val - rt_val;
               6'b100100: exp_val = rs_val & rt_val;
               6'b100101: exp_val = rs_val | rt_val;
               6'b101010: exp_val = {31'd0, $signed(rs_val) < $signed(rt_val)};
               6'b000100: exp_val = rt_val << rs_val[4:0];
               6'b000110: exp_val = rt_val >> rs_val[4:0];
               6'b000111: exp_val = $signed(rt_val) >>> rs_val[4:0];
               default: begin
                  writer  = 1'b0;
                  illegal = 1'b1;
               end
            endcase
         end
         6'b011111: begin
            writer  = 1'b1;
            exp_val = qb_add(rs_val, rt_val, shamt == 5'b00100);
         end
         6'b001000: begin
            writer  = 1'b1;
            dest    = rt_idx;
            exp_val = rs_val + {{16{IF_INSTRUCTION[15]}}, IF_INSTRUCTION[15:0]};
         end
         6'b000100, 6'b000111: writer = 1'b0;
         6'b000011: begin
            writer  = 1'b1;
            dest    = 5'd31;
            exp_val = IF_PC + 32'd4;
         end
         default: illegal = 1'b1;
      endcase
   end

   // A writer targeting $0 is treated as a non-writer, so a DUT write elsewhere is spurious.
   always_comb begin
      err_det  = 1'b0;
      err_code = 2'd0;
      err_reg  = '0;
      err_exp  = '0;
      err_got  = '0;
      sh_we    = 1'b0;
      sh_idx   = '0;
      sh_val   = '0;
      if (illegal) begin
         err_det  = 1'b1;
         err_code = 2'd3;
         err_got  = IF_WDATA;
      end else if (writer && dest != 5'd0) begin
         err_reg = dest;
         err_exp = exp_val;
         sh_we   = 1'b1;
         sh_idx  = dest;
         sh_val  = exp_val;
         if (!IF_WE) begin
            err_det  = 1'b1;
            err_code = 2'd1;
         end else if (IF_WADDR != dest || IF_WDATA != exp_val) begin
            err_det  = 1'b1;
            err_code = 2'd0;
            err_got  = IF_WDATA;
            if (RESYNC) begin
               sh_idx = IF_WADDR;
               sh_val = IF_WDATA;
            end
         end
      end else if (IF_WE && IF_WADDR != 5'd0) begin
         err_det  = 1'b1;
         err_code = 2'd2;
         err_reg  = IF_WADDR;
         err_got  = IF_WDATA;
      end
   end

   assign check_en = (state == ST_RUN) && IF_RETIRE;
   assign full     = count == (PW+1)'(ERR_DEPTH);
   assign pop      = ERR_VALID && ERR_READY;
   assign push_ok  = check_en && err_det && (!full || pop);

   always_ff @(posedge IF_CLK or negedge IF_RESET_N) begin
      if (!IF_RESET_N) begin
         state     <= ST_RUN;
         prev_pc   <= '0;
         stall_tmr <= TMR_RELOAD;
      end else if (state == ST_RUN) begin
         prev_pc <= IF_PC;
         if (IF_PC != prev_pc)
            stall_tmr <= TMR_RELOAD;
         else if (stall_tmr == TW'(1))
            state <= (IF_PC == END_PC) ? ST_DONE : ST_HANG;
         else
            stall_tmr <= stall_tmr - TW'(1);
      end
   end

   always_ff @(posedge IF_CLK or negedge IF_RESET_N) begin
      if (!IF_RESET_N) begin
         for (int i = 0; i < 32; i++) shadow[i] <= '0;
      end else if (check_en && sh_we && sh_idx != 5'd0 && 32'(sh_idx) < NUM_REGS) begin
         shadow[sh_idx] <= sh_val;
      end
   end

   always_ff @(posedge IF_CLK or negedge IF_RESET_N) begin
      if (!IF_RESET_N) begin
         RETIRED_CNT  <= '0;
         ERR_CNT      <= '0;
         ERR_OVERFLOW <= 1'b0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
      end else begin
         if (check_en) RETIRED_CNT <= RETIRED_CNT + 32'd1;
         if (check_en && err_det && ERR_CNT != 16'hFFFF) ERR_CNT <= ERR_CNT + 16'd1;
         if (check_en && err_det && !push_ok) ERR_OVERFLOW <= 1'b1;
         if (push_ok) wr_ptr <= wr_ptr + PW'(1);
         if (pop) rd_ptr <= rd_ptr + PW'(1);
         case ({push_ok, pop})
            2'b10:   count <= count + (PW+1)'(1);
            2'b01:   count <= count - (PW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge IF_CLK) begin
      if (push_ok) begin
         q_code[wr_ptr] <= err_code;
         q_pc[wr_ptr]   <= IF_PC;
         q_reg[wr_ptr]  <= err_reg;
         q_exp[wr_ptr]  <= err_exp;
         q_got[wr_ptr]  <= err_got;
      end
   end

   assign ERR_VALID = count != '0;
   assign ERR_CODE  = ERR_VALID ? q_code[rd_ptr] : '0;
   assign ERR_PC    = ERR_VALID ? q_pc[rd_ptr]   : '0;
   assign ERR_REG   = ERR_VALID ? q_reg[rd_ptr]  : '0;
   assign ERR_EXP   = ERR_VALID ? q_exp[rd_ptr]  : '0;
   assign ERR_GOT   = ERR_VALID ? q_got[rd_ptr]  : '0;
   assign DONE      = state == ST_DONE;
   assign HANG      = state == ST_HANG;

endmodule

// File: tb/tb_lockstep_shadow_checker.sv
// Bench for lockstep_shadow_checker: directed scenarios plus random retirements,
// checked against a queue-based reference model of the checker's rules.
module tb_lockstep_shadow_checker;

   localparam int unsigned DEPTH   = 8;
   localparam int unsigned TIMEOUT = 16;
   localparam logic [31:0] END_PC  = 32'h3FC;
   localparam bit          RESYNC  = 1'b1;

   logic        clk, rst_n;
   logic [31:0] if_pc, if_instr, if_wdata;
   logic        if_retire, if_we, err_ready;
   logic [4:0]  if_waddr;
   logic        err_valid, err_overflow, done, hang;
   logic [1:0]  err_code;
   logic [31:0] err_pc, err_exp, err_got, retired_cnt;
   logic [4:0]  err_reg;
   logic [15:0] err_cnt;

   lockstep_shadow_checker #(
      .NUM_REGS(32), .ERR_DEPTH(DEPTH), .TIMEOUT_CYC(TIMEOUT), .END_PC(END_PC), .RESYNC(RESYNC)
   ) dut (
      .IF_CLK(clk), .IF_RESET_N(rst_n), .IF_PC(if_pc), .IF_INSTRUCTION(if_instr),
      .IF_RETIRE(if_retire), .IF_WE(if_we), .IF_WADDR(if_waddr), .IF_WDATA(if_wdata),
      .ERR_VALID(err_valid), .ERR_READY(err_ready), .ERR_CODE(err_code), .ERR_PC(err_pc),
      .ERR_REG(err_reg), .ERR_EXP(err_exp), .ERR_GOT(err_got), .ERR_OVERFLOW(err_overflow),
      .RETIRED_CNT(retired_cnt), .ERR_CNT(err_cnt), .DONE(done), .HANG(hang)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0]  code;
      logic [31:0] pc;
      logic [4:0]  rg;
      logic [31:0] ex;
      logic [31:0] got;
   } err_t;

   logic [31:0] m_shadow [32];
   err_t        m_q[$];
   bit          m_ovf, m_done, m_hang;
   logic [31:0] m_ret, m_prev;
   logic [15:0] m_errc;
   int          m_stall;

   int          n_total, n_bad;
   logic [31:0] cur_pc;
   logic        rdy_g;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Expected destination/value straight from the ISA description, using the model's shadow.
   function automatic void ref_decode(input logic [31:0] ins, input logic [31:0] p,
                                      output bit wr, output bit ill,
                                      output logic [4:0] d, output logic [31:0] v);
      logic [31:0] a, b;
      int s, t;
      a = m_shadow[ins[25:21]];
      b = m_shadow[ins[20:16]];
      s = int'(a[4:0]);
      wr = 1; ill = 0; d = ins[15:11]; v = 0;
      case (ins[31:26])
         6'h00: case (ins[5:0])
            6'h20: v = a + b;
            6'h22: v = a - b;
            6'h24: v = a & b;
            6'h25: v = a | b;
            6'h2A: v = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            6'h04: v = b << s;
            6'h06: v = b >> s;
            6'h07: begin
               v = b >> s;
               if (b[31]) v = v | ~(32'hFFFF_FFFF >> s);
            end
            default: begin wr = 0; ill = 1; end
         endcase
         6'h1F: for (int k = 0; k < 4; k++) begin
            t = int'(a[8*k +: 8]) + int'(b[8*k +: 8]);
            if (ins[10:6] == 5'd4 && t > 255) t = 255;
            v[8*k +: 8] = t[7:0];
         end
         6'h08: begin d = ins[20:16]; v = a + {{16{ins[15]}}, ins[15:0]}; end
         6'h04, 6'h07: wr = 0;
         6'h03: begin d = 5'd31; v = p + 32'd4; end
         default: begin wr = 0; ill = 1; end
      endcase
      if (!wr) d = 0;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_shadow[i] = '0;
      m_q.delete();
      m_ovf = 0; m_done = 0; m_hang = 0;
      m_ret = '0; m_errc = '0; m_prev = '0; m_stall = 0;
   endtask

   task automatic model_edge();
      bit wr, ill, has, running;
      logic [4:0] d;
      logic [31:0] v;
      err_t e;
      running = !m_done && !m_hang;
      if (m_q.size() > 0 && err_ready) void'(m_q.pop_front());
      if (running && if_retire) begin
         ref_decode(if_instr, if_pc, wr, ill, d, v);
         has = 0; e = '0; e.pc = if_pc;
         if (ill) begin
            has = 1; e.code = 3; e.got = if_wdata;
         end else if (wr && d != 0) begin
            if (!if_we) begin
               has = 1; e.code = 1; e.rg = d; e.ex = v;
            end else if (if_waddr != d || if_wdata != v) begin
               has = 1; e.code = 0; e.rg = d; e.ex = v; e.got = if_wdata;
            end
            if (has && e.code == 0 && RESYNC) begin
               if (if_waddr != 0) m_shadow[if_waddr] = if_wdata;
            end else m_shadow[d] = v;
         end else if (if_we && if_waddr != 0) begin
            has = 1; e.code = 2; e.rg = if_waddr; e.got = if_wdata;
         end
         m_ret++;
         if (has) begin
            if (m_errc != 16'hFFFF) m_errc++;
            if (m_q.size() < DEPTH) m_q.push_back(e);
            else m_ovf = 1;
         end
      end
      if (running) begin
         if (if_pc == m_prev) m_stall++;
         else m_stall = 0;
         m_prev = if_pc;
         if (m_stall == TIMEOUT) begin
            if (if_pc == END_PC) m_done = 1;
            else m_hang = 1;
         end
      end
   endtask

   task automatic check_all();
      chk("err_valid", 32'(err_valid), 32'(m_q.size() > 0));
      if (m_q.size() > 0) begin
         chk("err_code", 32'(err_code), 32'(m_q[0].code));
         chk("err_pc", err_pc, m_q[0].pc);
         chk("err_reg", 32'(err_reg), 32'(m_q[0].rg));
         chk("err_exp", err_exp, m_q[0].ex);
         chk("err_got", err_got, m_q[0].got);
      end
      chk("err_overflow", 32'(err_overflow), 32'(m_ovf));
      chk("retired_cnt", retired_cnt, m_ret);
      chk("err_cnt", 32'(err_cnt), 32'(m_errc));
      chk("done", 32'(done), 32'(m_done));
      chk("hang", 32'(hang), 32'(m_hang));
   endtask

   task automatic step(input logic [31:0] p, input logic [31:0] ins, input logic r,
                       input logic w, input logic [4:0] a, input logic [31:0] d, input logic y);
      @(negedge clk);
      if_pc = p; if_instr = ins; if_retire = r;
      if_we = w; if_waddr = a; if_wdata = d; err_ready = y;
      model_edge();
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic exec(input logic [31:0] ins, input logic w, input logic [4:0] a,
                       input logic [31:0] d);
      cur_pc = cur_pc + 32'd4;
      step(cur_pc, ins, 1'b1, w, a, d, rdy_g);
   endtask

   task automatic idle();
      cur_pc = cur_pc + 32'd4;
      step(cur_pc, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, rdy_g);
   endtask

   task automatic reset_task();
      @(negedge clk);
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("rst_err_valid", 32'(err_valid), 32'd0);
      chk("rst_retired", retired_cnt, 32'd0);
      chk("rst_err_cnt", 32'(err_cnt), 32'd0);
      chk("rst_overflow", 32'(err_overflow), 32'd0);
      chk("rst_done_hang", {30'd0, done, hang}, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   function automatic logic [31:0] r_ins(input logic [5:0] f, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] rd);
      return {6'h00, rs, rt, rd, 5'd0, f};
   endfunction

   function automatic logic [31:0] addi(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [15:0] imm);
      return {6'h08, rs, rt, imm};
   endfunction

   task automatic rand_step();
      logic [31:0] ins, v, wd;
      logic [4:0]  rs, rt, rd, d, wa;
      logic [5:0]  f;
      bit wr, ill;
      logic we;
      int mode;
      rs = 5'($urandom_range(0, 7));
      rt = 5'($urandom_range(0, 7));
      rd = 5'($urandom_range(0, 7));
      case ($urandom_range(0, 7))
         0: f = 6'h07;
         1: f = 6'h20;
         2: f = 6'h22;
         3: f = 6'h24;
         4: f = 6'h25;
         5: f = 6'h2A;
         6: f = 6'h04;
         default: f = 6'h06;
      endcase
      case ($urandom_range(0, 8))
         0, 1: ins = r_ins(f, rs, rt, rd);
         2: ins = {6'h1F, rs, rt, rd, ($urandom_range(0, 1) != 0) ? 5'd4 : 5'd0, 6'h10};
         3: ins = addi(rs, rt, 16'($urandom));
         4: ins = {6'h04, rs, rt, 16'($urandom)};
         5: ins = {6'h07, rs, rt, 16'h0};
         6: ins = {6'h03, 26'($urandom)};
         7: ins = r_ins(6'h08, rs, rt, rd);
         default: ins = {6'h2B, 26'($urandom)};
      endcase
      cur_pc = cur_pc + 32'd4;
      ref_decode(ins, cur_pc, wr, ill, d, v);
      mode = int'($urandom_range(0, 9));
      we = 1'b0; wa = 5'd0; wd = $urandom;
      if (mode <= 5) begin
         if (wr && d != 0) begin we = 1'b1; wa = d; wd = v; end
      end else if (mode <= 7) begin
         we = 1'b1;
         wa = (mode == 6) ? d : 5'($urandom_range(0, 7));
         wd = v ^ 32'($urandom_range(1, 255));
      end else if (mode == 9) begin
         we = 1'b1;
         wa = 5'($urandom_range(0, 7));
      end
      step(cur_pc, ins, $urandom_range(0, 7) != 0, we, wa, wd, $urandom_range(0, 3) != 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_total = 0; n_bad = 0;
      rst_n = 1'b0; if_pc = '0; if_instr = '0; if_retire = 1'b0;
      if_we = 1'b0; if_waddr = '0; if_wdata = '0; err_ready = 1'b0;
      cur_pc = 32'h400; rdy_g = 1'b1;
      reset_task();

      exec(addi(5'd0, 5'd5, 16'h7FFF), 1'b1, 5'd5, 32'h7FFF);
      chk("t1_retired", retired_cnt, 32'd1);
      chk("t1_no_err", 32'(err_valid), 32'd0);
      exec(r_ins(6'h20, 5'd5, 5'd0, 5'd6), 1'b1, 5'd6, 32'h7FFF);
      chk("t1_shadow5", 32'(err_valid), 32'd0);

      exec(addi(5'd0, 5'd1, 16'h0), 1'b1, 5'd1, 32'h80FF00FE);
      exec(addi(5'd0, 5'd2, 16'h0), 1'b1, 5'd2, 32'h01020304);
      exec({6'h1F, 5'd1, 5'd2, 5'd3, 5'd4, 6'h10}, 1'b1, 5'd3, 32'h81FF0302);
      chk("t2_code", 32'(err_code), 32'd0);
      chk("t2_exp", err_exp, 32'h81FF03FF);
      chk("t2_got", err_got, 32'h81FF0302);
      exec(r_ins(6'h20, 5'd3, 5'd0, 5'd4), 1'b1, 5'd4, 32'h81FF0302);
      chk("t2_resync", 32'(err_valid), 32'd0);

      exec({6'h04, 5'd1, 5'd2, 16'h0010}, 1'b1, 5'd7, 32'h1234);
      chk("t3_spurious_code", 32'(err_code), 32'd2);
      chk("t3_spurious_reg", 32'(err_reg), 32'd7);
      cur_pc = 32'h3C;
      exec({6'h03, 26'h10}, 1'b0, 5'd0, 32'h0);
      chk("t3_missing_code", 32'(err_code), 32'd1);
      chk("t3_missing_exp", err_exp, 32'h44);
      chk("t3_missing_reg", 32'(err_reg), 32'd31);
      exec({6'h3F, 26'h0}, 1'b0, 5'd0, 32'h0);
      chk("t3_illegal_code", 32'(err_code), 32'd3);
      for (int i = 0; i < 10; i++) idle();
      chk("drain_empty", 32'(err_valid), 32'd0);

      rdy_g = 1'b0;
      for (int k = 1; k <= 9; k++)
         exec(addi(5'd0, 5'd9, 16'(k)), 1'b1, 5'd9, 32'hDEAD0000 + 32'(k));
      chk("t4_overflow", 32'(err_overflow), 32'd1);
      chk("t4_head", err_got, 32'hDEAD0001);
      rdy_g = 1'b1;
      for (int i = 0; i < 8; i++) idle();
      chk("t4_empty", 32'(err_valid), 32'd0);

      rdy_g = 1'b0;
      for (int k = 1; k <= 3; k++)
         exec(addi(5'd0, 5'd10, 16'(k)), 1'b1, 5'd10, 32'hBEEF0000);
      chk("t6_queued", 32'(err_valid), 32'd1);
      reset_task();
      rdy_g = 1'b1;
      exec(r_ins(6'h20, 5'd1, 5'd3, 5'd6), 1'b1, 5'd6, 32'h0);
      chk("t6_shadow_clear", 32'(err_valid), 32'd0);
      chk("t6_retired", retired_cnt, 32'd1);

      for (int n = 0; n < 300; n++) rand_step();

      for (int i = 0; i < int'(TIMEOUT) + 3; i++)
         step(32'h100, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
      chk("t5_hang", 32'(hang), 32'd1);
      chk("t5_hang_not_done", 32'(done), 32'd0);
      step(32'h100, {6'h04, 26'h0}, 1'b1, 1'b1, 5'd3, 32'h5, 1'b1);

      reset_task();
      step(32'h3F8, addi(5'd0, 5'd9, 16'h1), 1'b1, 1'b1, 5'd9, 32'h5, 1'b0);
      for (int i = 0; i < int'(TIMEOUT) + 3; i++)
         step(END_PC, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
      chk("t5_done", 32'(done), 32'd1);
      chk("t5_done_not_hang", 32'(hang), 32'd0);
      chk("t5_pending", 32'(err_valid), 32'd1);
      step(END_PC, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
      chk("t5_drain_after_done", 32'(err_valid), 32'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
